// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destinations past ID, picks forwarding
// selects per source, stalls on load-use (or any RAW without forwarding), counts stalls/flushes.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int FORWARD  = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wb,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wb;
        logic              ld;
    } entry_t;

    entry_t [DEPTH-1:0]    sb;
    logic   [1:0]          req;
    logic   [1:0][SEL_W-1:0] sel;

    always_comb begin
        logic [REG_AW-1:0] s;
        logic              live;
        logic              hit;
        logic [SEL_W-1:0]  hk;
        req = '0;
        sel = '0;
        for (int g = 0; g < 2; g++) begin
            s    = (g == 1) ? id_rs2 : id_rs1;
            live = id_valid & ((g == 1) ? id_rs2_used : id_rs1_used) & ~(ZERO_REG != 0 && s == '0);
            hit  = 1'b0;
            hk   = '0;
            // scan oldest to youngest so the youngest match overwrites
            for (int k = DEPTH - 1; k >= 0; k--)
                if (sb[k].v && sb[k].wb && sb[k].rd == s) begin
                    hit = 1'b1;
                    hk  = SEL_W'(k);
                end
            req[g] = live & hit & ((FORWARD == 0) | (hk == '0 & sb[0].ld));
            sel[g] = (FORWARD != 0 && live && hit && !req[g]) ? hk + 1'b1 : '0;
        end
    end

    assign stall = (|req) & ~flush;
    assign fwd_a = stall ? '0 : sel[0];
    assign fwd_b = stall ? '0 : sel[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb        <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            sb[0] <= (id_valid & ~stall & ~flush) ? {1'b1, id_rd, id_wb, id_is_load} : '0;
            for (int k = 1; k < DEPTH; k++)
                sb[k] <= sb[k-1];
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors push expected outputs into a queue;
// a negedge monitor pops and compares against the selected DUT.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       id_wb = 1'b0, id_is_load = 1'b0, flush = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

    logic        stall0, stall1;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [15:0] sc0, fc0;
    logic [1:0]  sc1, fc1;

    always #5 clk = ~clk;

    hazard_scoreboard #(.FORWARD(1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wb(id_wb),
        .id_is_load(id_is_load), .flush(flush), .stall(stall0), .fwd_a(fa0), .fwd_b(fb0),
        .stall_cnt(sc0), .flush_cnt(fc0));

    // narrow counters so saturation is reachable in a few cycles
    hazard_scoreboard #(.FORWARD(0), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wb(id_wb),
        .id_is_load(id_is_load), .flush(flush), .stall(stall1), .fwd_a(fa1), .fwd_b(fb1),
        .stall_cnt(sc1), .flush_cnt(fc1));

    typedef struct {
        int id;
        int d;
        int st, fa, fb, sc, fc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vid   = 0;

    task automatic v(input int r, va, rs1, u1, rs2, u2, rd, wb, ld, fl,
                     input int d, st, fa, fb, sc, fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r[0]; id_valid = va[0];
        id_rs1 = 5'(rs1); id_rs1_used = u1[0];
        id_rs2 = 5'(rs2); id_rs2_used = u2[0];
        id_rd = 5'(rd); id_wb = wb[0]; id_is_load = ld[0]; flush = fl[0];
        e.id = vid; e.d = d; e.st = st; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
        q.push_back(e);
        vid++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   st, fa, fb, sc, fc;
        if (q.size() > 0) begin
            e  = q.pop_front();
            st = e.d != 0 ? int'(stall1) : int'(stall0);
            fa = e.d != 0 ? int'(fa1) : int'(fa0);
            fb = e.d != 0 ? int'(fb1) : int'(fb0);
            sc = e.d != 0 ? int'(sc1) : int'(sc0);
            fc = e.d != 0 ? int'(fc1) : int'(fc0);
            n_cmp++;
            if (st != e.st || fa != e.fa || fb != e.fb || sc != e.sc || fc != e.fc) begin
                n_bad++;
                $display("FAIL vec%0d dut%0d: got stall=%0d fwd_a=%0d fwd_b=%0d stall_cnt=%0d flush_cnt=%0d, want stall=%0d fwd_a=%0d fwd_b=%0d stall_cnt=%0d flush_cnt=%0d",
                         e.id, e.d, st, fa, fb, sc, fc, e.st, e.fa, e.fb, e.sc, e.fc);
            end
        end
    end

    initial begin
        //  rst va rs1 u1 rs2 u2 rd wb ld fl | dut st fa fb sc fc
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // ALU RAW distances 1..4
        v(1, 1, 0, 0, 0, 0, 3, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 1, 3, 1, 0, 0, 10, 1, 0, 0,  0, 0, 1, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 4, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 1, 4, 1, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 6, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 1, 6, 1, 6, 1, 0, 0, 0, 0,   0, 0, 3, 3, 0, 0);
        v(1, 1, 0, 0, 0, 0, 8, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 1, 8, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // two sources matching different entries
        v(1, 1, 0, 0, 0, 0, 11, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0, 12, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        v(1, 1, 11, 1, 12, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        // load-use: one bubble, then forward from MEM
        v(1, 1, 0, 0, 0, 0, 5, 1, 1, 0,   0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 5, 1, 13, 1, 0, 0,  0, 1, 0, 0, 0, 0);
        v(1, 1, 0, 0, 5, 1, 13, 1, 0, 0,  0, 0, 0, 2, 1, 0);
        // zero register and youngest-wins
        v(1, 1, 0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 1, 0);
        v(1, 1, 0, 1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        v(1, 1, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, 0, 0, 1, 0);
        v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        v(1, 1, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, 0, 0, 1, 0);
        v(1, 1, 7, 1, 0, 0, 15, 1, 0, 0,  0, 0, 1, 0, 1, 0);
        // flush overrides a pending load-use stall
        v(1, 1, 0, 0, 0, 0, 5, 1, 1, 0,   0, 0, 0, 0, 1, 0);
        v(1, 1, 5, 1, 0, 0, 14, 1, 0, 1,  0, 0, 0, 0, 1, 0);
        v(1, 1, 5, 1, 15, 1, 0, 0, 0, 0,  0, 0, 2, 3, 1, 1);
        // asynchronous reset mid-operation
        v(1, 1, 0, 0, 0, 0, 5, 1, 1, 0,   0, 0, 0, 0, 1, 1);
        v(0, 1, 0, 0, 5, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 5, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // no forwarding: stall until producer leaves WB, counter saturates
        v(1, 1, 0, 0, 0, 0, 2, 1, 0, 0,   1, 0, 0, 0, 0, 0);
        v(1, 1, 2, 1, 0, 0, 16, 1, 0, 0,  1, 1, 0, 0, 0, 0);
        v(1, 1, 2, 1, 0, 0, 16, 1, 0, 0,  1, 1, 0, 0, 1, 0);
        v(1, 1, 2, 1, 0, 0, 16, 1, 0, 0,  1, 1, 0, 0, 2, 0);
        v(1, 1, 2, 1, 0, 0, 16, 1, 0, 0,  1, 0, 0, 0, 3, 0);
        v(1, 1, 16, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 3, 0);
        v(1, 1, 16, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 3, 0);
        v(1, 1, 16, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 3, 0);
        v(1, 1, 16, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 3, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 3, 1);
        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
